// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the tap search and the downstream decrypter.
package lfsr_pkg;

  localparam int         LFSR_W        = 7;
  localparam logic [7:0] PREAMBLE_CHAR = 8'h20;
  localparam logic [3:0] PTRN_NONE     = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, DONE} search_state_t;

  // Shift left, feedback bit is the parity of the tapped state bits.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] taps);
    return {s[LFSR_W-2:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_tap_search_preamble_buf.sv
// Capture buffer for the encrypted preamble bytes; fills in order, stops when full.
module preamble_buf #(
  parameter int PRE_LEN = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clr,
  input  logic                    i_wr,
  input  logic [7:0]              i_data,
  output logic                    o_first,
  output logic                    o_last,
  output logic [PRE_LEN-1:0][7:0] o_bytes
);
  localparam int PW = $clog2(PRE_LEN + 1);
  localparam int IW = $clog2(PRE_LEN);

  logic [PW-1:0]            r_wptr;
  logic [PRE_LEN-1:0][7:0]  r_bytes;
  logic                     w_full;
  logic                     w_wr;

  assign w_full  = (r_wptr == PW'(PRE_LEN));
  assign w_wr    = i_wr && !w_full;
  assign o_first = w_wr && (r_wptr == '0);
  assign o_last  = w_wr && (r_wptr == PW'(PRE_LEN - 1));
  assign o_bytes = r_bytes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_bytes <= '0;
    end else if (i_clr) begin
      r_wptr <= '0;
    end else if (w_wr) begin
      r_bytes[r_wptr[IW-1:0]] <= i_data;
      r_wptr                  <= r_wptr + PW'(1);
    end
  end

endmodule

// File: rtl/lfsr_tap_search.sv
// Recovers the LFSR seed from a known preamble and searches the tap table for the
// pattern whose keystream reproduces the captured cipher bytes.
module lfsr_tap_search
  import lfsr_pkg::*;
#(
  parameter int         PRE_LEN  = 6,
  parameter int         NUM_PTRN = 9,
  parameter logic [7:0] PREAMBLE = PREAMBLE_CHAR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [3:0]  ptrn_number,
  input  logic [7:0]  tap_ptrn,
  output logic        done,
  output logic        found,
  output logic [3:0]  match_ptrn,
  output logic [6:0]  seed,
  output logic [6:0]  lfsr_state
);
  localparam int IW = $clog2(PRE_LEN);

  search_state_t           r_state, w_state_nx;
  logic [3:0]              r_ptrn, w_ptrn_nx;
  logic [LFSR_W-1:0]       r_s, w_s_nx;
  logic [IW-1:0]           r_i, w_i_nx;
  logic [LFSR_W-1:0]       r_seed, w_seed_nx;
  logic                    r_done, w_done_nx;
  logic                    r_found, w_found_nx;
  logic [3:0]              r_match, w_match_nx;
  logic [LFSR_W-1:0]       r_lfsr, w_lfsr_nx;

  logic                    w_clr, w_wr, w_first, w_last, w_hit;
  logic [LFSR_W-1:0]       w_s_step;
  logic [PRE_LEN-1:0][7:0] w_bytes;
  logic                    w_unused_tap7;

  assign w_unused_tap7 = tap_ptrn[7];
  assign in_ready      = (r_state == LOAD);
  assign w_wr          = in_valid && in_ready;

  preamble_buf #(.PRE_LEN(PRE_LEN)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_clr),
    .i_wr    (w_wr),
    .i_data  (in_data),
    .o_first (w_first),
    .o_last  (w_last),
    .o_bytes (w_bytes)
  );

  // The MSB of every predicted byte is the preamble MSB, so compare all 8 bits.
  assign w_s_step = lfsr_next(r_s, tap_ptrn[6:0]);
  assign w_hit    = (({1'b0, w_s_step} ^ PREAMBLE) == w_bytes[r_i]);

  always_comb begin
    w_state_nx = r_state;
    w_ptrn_nx  = r_ptrn;
    w_s_nx     = r_s;
    w_i_nx     = r_i;
    w_seed_nx  = r_seed;
    w_done_nx  = r_done;
    w_found_nx = r_found;
    w_match_nx = r_match;
    w_lfsr_nx  = r_lfsr;
    w_clr      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nx = LOAD;
          w_done_nx  = 1'b0;
          w_found_nx = 1'b0;
          w_clr      = 1'b1;
        end
      end
      LOAD: begin
        if (w_first) w_seed_nx = in_data[6:0] ^ PREAMBLE[6:0];
        if (w_last) begin
          w_ptrn_nx = '0;
          w_s_nx    = r_seed;
          w_i_nx    = IW'(1);
          // A zero seed never leaves zero, so no pattern can be identified.
          if (r_seed == '0) begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
            w_found_nx = 1'b0;
            w_match_nx = PTRN_NONE;
            w_lfsr_nx  = '0;
          end else begin
            w_state_nx = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (w_hit) begin
          if (r_i == IW'(PRE_LEN - 1)) begin
            w_state_nx = DONE;
            w_done_nx  = 1'b1;
            w_found_nx = 1'b1;
            w_match_nx = r_ptrn;
            w_lfsr_nx  = w_s_step;
          end else begin
            w_s_nx = w_s_step;
            w_i_nx = r_i + IW'(1);
          end
        end else if (r_ptrn == 4'(NUM_PTRN - 1)) begin
          w_state_nx = DONE;
          w_done_nx  = 1'b1;
          w_found_nx = 1'b0;
          w_match_nx = PTRN_NONE;
          w_lfsr_nx  = '0;
        end else begin
          w_ptrn_nx = r_ptrn + 4'd1;
          w_s_nx    = r_seed;
          w_i_nx    = IW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptrn  <= '0;
      r_s     <= '0;
      r_i     <= '0;
      r_seed  <= '0;
      r_done  <= 1'b0;
      r_found <= 1'b0;
      r_match <= PTRN_NONE;
      r_lfsr  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptrn  <= w_ptrn_nx;
      r_s     <= w_s_nx;
      r_i     <= w_i_nx;
      r_seed  <= w_seed_nx;
      r_done  <= w_done_nx;
      r_found <= w_found_nx;
      r_match <= w_match_nx;
      r_lfsr  <= w_lfsr_nx;
    end
  end

  assign ptrn_number = r_ptrn;
  assign done        = r_done;
  assign found       = r_found;
  assign match_ptrn  = r_match;
  assign seed        = r_seed;
  assign lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_lfsr_tap_search.sv
// Scoreboard bench for lfsr_tap_search: directed preamble vectors, results checked on done.
module tb_lfsr_tap_search;

  logic       clk, reset_n, start, in_valid, in_ready;
  logic [7:0] in_data, tap_ptrn;
  logic [3:0] ptrn_number, match_ptrn;
  logic       done, found;
  logic [6:0] seed, lfsr_state;

  logic [7:0] tbl [16];
  assign tap_ptrn = tbl[ptrn_number];

  lfsr_tap_search #(.PRE_LEN(6), .NUM_PTRN(9), .PREAMBLE(8'h20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ptrn_number(ptrn_number), .tap_ptrn(tap_ptrn), .done(done),
    .found(found), .match_ptrn(match_ptrn), .seed(seed), .lfsr_state(lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       found;
    logic [3:0] match;
    logic [6:0] seed;
    logic [6:0] lfsr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  logic arm_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts cycles from the last preamble byte and checks results on done rising.
  int   cyc = 0;
  logic armed = 1'b0, prev_done = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (arm_req) begin cyc = 0; armed = 1'b1; arm_req = 1'b0; end
    else if (armed) cyc++;
    if (done && !prev_done) begin
      armed = 1'b0;
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("found",      32'(found),      32'(e.found));
        chk("match_ptrn", 32'(match_ptrn), 32'(e.match));
        chk("seed",       32'(seed),       32'(e.seed));
        chk("lfsr_state", 32'(lfsr_state), 32'(e.lfsr));
        if (e.cyc >= 0) chk("search_cycles", 32'(cyc), 32'(e.cyc));
      end
    end
    prev_done = done;
  end

  task automatic start_pulse();
    @(negedge clk); start = 1'b1; in_valid = 1'b0;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gaps, input logic last);
    repeat (gaps) begin @(negedge clk); in_valid = 1'b0; in_data = 8'h5A; end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    if (!in_ready) chk("in_ready_in_load", 32'(in_ready), 32'd1);
    if (last) arm_req = 1'b1;
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic send_all(input logic [47:0] bytes, input int gaps);
    for (int k = 0; k < 6; k++) send_byte(bytes[k*8 +: 8], (k == 0) ? 0 : gaps, k == 5);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 300) begin @(posedge clk); #2; k++; end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  task automatic push(input logic f, input logic [3:0] m, input logic [6:0] s,
                      input logic [6:0] l, input int c);
    exp_t e;
    e.found = f; e.match = m; e.seed = s; e.lfsr = l; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},    32'(in_ready),    32'd0);
    chk({tag, "_done"},        32'(done),        32'd0);
    chk({tag, "_found"},       32'(found),       32'd0);
    chk({tag, "_match_ptrn"},  32'(match_ptrn),  32'hF);
    chk({tag, "_ptrn_number"}, 32'(ptrn_number), 32'd0);
    chk({tag, "_seed"},        32'(seed),        32'd0);
    chk({tag, "_lfsr_state"},  32'(lfsr_state),  32'd0);
  endtask

  // Bytes packed with byte 0 in the low 8 bits.
  localparam logic [47:0] S1 = 48'h00_30_28_24_22_21;
  localparam logic [47:0] S2 = 48'h03_31_28_24_22_21;
  localparam logic [47:0] S3 = 48'hFF_30_28_24_22_21;
  localparam logic [47:0] S4 = 48'h00_30_28_24_22_20;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = 8'h60; tbl[1] = 8'h48; tbl[2] = 8'h78; tbl[3] = 8'h71; tbl[4] = 8'h5C;
    tbl[5] = 8'h66; tbl[6] = 8'h41; tbl[7] = 8'h0F; tbl[8] = 8'h3A;
    for (int k = 9; k < 16; k++) tbl[k] = 8'h00;
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset_n = 1'b1;

    // First pattern matches outright.
    push(1'b1, 4'd0, 7'h01, 7'h20, 5);
    start_pulse(); send_all(S1, 0); wait_done();

    // Patterns 0 and 1 fail late, pattern 2 matches.
    push(1'b1, 4'd2, 7'h01, 7'h23, 14);
    start_pulse(); send_all(S2, 0); wait_done();

    // Last byte has bit 7 set: nothing can match.
    push(1'b0, 4'hF, 7'h01, 7'h00, -1);
    start_pulse(); send_all(S3, 0); wait_done();
    repeat (10) @(negedge clk);
    chk("done_held", 32'(done), 32'd1);
    chk("found_held", 32'(found), 32'd0);

    // Zero seed: straight to DONE.
    push(1'b0, 4'hF, 7'h00, 7'h00, 0);
    start_pulse();
    chk("done_cleared_on_start", 32'(done), 32'd0);
    send_all(S4, 0); wait_done();

    // Junk valid outside LOAD, gapped valid, start during SEARCH.
    @(negedge clk); in_valid = 1'b1; in_data = 8'hAA;
    repeat (2) @(negedge clk);
    push(1'b1, 4'd0, 7'h01, 7'h20, 5);
    start_pulse(); send_all(S1, 2);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();

    // Reset mid-SEARCH, then rerun the first scenario.
    start_pulse(); send_all(S2, 0);
    repeat (6) @(negedge clk);
    reset_n = 1'b0; #1;
    chk_reset_vals("midrst");
    @(negedge clk); reset_n = 1'b1;
    push(1'b1, 4'd0, 7'h01, 7'h20, 5);
    start_pulse(); send_all(S1, 0); wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
